// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and controller states.
// Combinational helper only; no state lives here.
package riscv_core_p;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } ForwardSel;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_ERROR    = 2'b10
    } HazardState;

    localparam int WAIT_CNT_W = 8;
    localparam int PERF_CNT_W = 32;

    // MEM result is younger than WB, so it wins when both match.
    function automatic ForwardSel fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_forward.sv
// Operand forwarding selects for both EX source operands.
// Latency: combinational. Backpressure: none.
module riscv_forward_unit
    import riscv_core_p::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_RegWrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_RegWrite,
    output ForwardSel             forwardA,
    output ForwardSel             forwardB
);

    logic mem_live;
    logic wb_live;
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    assign mem_live = mem_RegWrite && (mem_rd != '0);
    assign wb_live  = wb_RegWrite && (wb_rd != '0);

    assign mem_hit_a = mem_live && (mem_rd == ex_rs1);
    assign mem_hit_b = mem_live && (mem_rd == ex_rs2);
    assign wb_hit_a  = wb_live && (wb_rd == ex_rs1);
    assign wb_hit_b  = wb_live && (wb_rd == ex_rs2);

    always_comb begin
        forwardA = fwd_pick(mem_hit_a, wb_hit_a);
        forwardB = fwd_pick(mem_hit_b, wb_hit_b);
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, dmem wait freeze (perf counters under HAZARD_PERF_CNT_EN).
// Latency: all enables/flushes/selects are combinational from inputs and FSM state; state updates on clk.
// Backpressure: dmem_ready low freezes every pipeline register; timeout parks the pipe in a sticky error.
module riscv_hazard_ctrl
    import riscv_core_p::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_MemRead,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_RegWrite,
    input  logic                  mem_MemRead,
    input  logic                  mem_MemWrite,
    input  logic                  mem_PCSrc,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_RegWrite,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  memwb_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt,
    output logic [PERF_CNT_W-1:0] wait_cnt_total
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT = WAIT_CNT_W'(MEM_TIMEOUT);

    HazardState            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    ForwardSel fwd_a;
    ForwardSel fwd_b;

    logic mem_acc;
    logic load_use;
    logic run_rules;
    logic freeze;
    logic branch_flush;
    logic stall;

    riscv_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .wb_rd        (wb_rd),
        .wb_RegWrite  (wb_RegWrite),
        .forwardA     (fwd_a),
        .forwardB     (fwd_b)
    );

    assign forwardA = fwd_a;
    assign forwardB = fwd_b;

    assign mem_acc  = mem_MemRead | mem_MemWrite;
    assign load_use = ex_MemRead && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // The cycle dmem_ready arrives in MEM_WAIT behaves exactly like RUN, so a
    // branch held in MEM during the wait takes effect then rather than being dropped.
    assign run_rules = (state == HZ_RUN) || ((state == HZ_MEM_WAIT) && dmem_ready);

    assign freeze = !run_rules || (mem_acc && !dmem_ready);

    assign branch_flush = !freeze && mem_PCSrc;
    assign stall        = !freeze && !mem_PCSrc && load_use;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (branch_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    assign mem_error = (state == HZ_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                HZ_RUN: begin
                    if (mem_acc && !dmem_ready) begin
                        state    <= HZ_MEM_WAIT;
                        wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                HZ_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= HZ_RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt == TIMEOUT) begin
                            state <= HZ_ERROR;
                        end
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                HZ_ERROR: begin
                    state <= HZ_ERROR;
                end
                default: begin
                    state    <= HZ_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt      <= '0;
            flush_cnt      <= '0;
            wait_cnt_total <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_flush) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (state == HZ_MEM_WAIT) begin
                wait_cnt_total <= wait_cnt_total + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed plus randomized bench for riscv_hazard_ctrl against a rule-level reference model.
module tb_riscv_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_MemRead, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_PCSrc;
    logic       wb_RegWrite, dmem_ready;
    logic       pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] forwardA, forwardB;
    logic       mem_error;

    int checks = 0;
    int errors = 0;
    // Reference model: 0 = running, 1 = waiting on dmem, 2 = timed out
    int m_state = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    riscv_hazard_ctrl #(.MEM_TIMEOUT(TMO), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .mem_rd(mem_rd),
        .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .mem_PCSrc(mem_PCSrc), .wb_rd(wb_rd),
        .wb_RegWrite(wb_RegWrite), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .memwb_write(memwb_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .forwardA(forwardA), .forwardB(forwardB), .mem_error(mem_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [4:0] writes();
        return {pc_write, ifid_write, idex_write, exmem_write, memwb_write};
    endfunction

    function automatic logic [2:0] flushes();
        return {ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic check_model(input string tag);
        bit acc, lu, halt, bfl, stl;
        logic [4:0] we;
        logic [2:0] fl;
        #2;
        acc  = mem_MemRead || mem_MemWrite;
        lu   = ex_MemRead && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        halt = (m_state == 2) || (m_state == 1 && !dmem_ready) || (acc && !dmem_ready);
        bfl  = !halt && mem_PCSrc;
        stl  = !halt && !mem_PCSrc && lu;
        we   = halt ? 5'b00000 : (stl ? 5'b00111 : 5'b11111);
        fl   = {bfl, bfl || stl, bfl};
        check($sformatf("%s/writes", tag), 32'(writes()), 32'(we));
        check($sformatf("%s/flushes", tag), 32'(flushes()), 32'(fl));
        check($sformatf("%s/fwdA", tag), 32'(forwardA), 32'(ref_fwd(ex_rs1)));
        check($sformatf("%s/fwdB", tag), 32'(forwardB), 32'(ref_fwd(ex_rs2)));
        check($sformatf("%s/err", tag), 32'(mem_error), 32'(m_state == 2));
    endtask

    task automatic tick();
        int ns = m_state;
        int nc = m_cnt;
        bit acc = mem_MemRead || mem_MemWrite;
        if (m_state == 0 && acc && !dmem_ready) begin
            ns = 1; nc = 1;
        end else if (m_state == 1) begin
            if (dmem_ready) begin
                ns = 0; nc = 0;
            end else begin
                if (m_cnt == TMO) ns = 2;
                nc = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
        @(posedge clk);
        m_state = ns;
        m_cnt   = nc;
        #1;
    endtask

    task automatic zero_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_MemRead = 0; mem_RegWrite = 0; mem_MemRead = 0; mem_MemWrite = 0;
        mem_PCSrc = 0; wb_RegWrite = 0; dmem_ready = 0;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        m_state = 0;
        m_cnt   = 0;
        check_model(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        check_model("reset");
        check("reset_pc", 32'(pc_write), 32'd1);
        rst = 1'b0;
        tick();

        // Load-use: one bubble, then the load has moved on
        zero_inputs(); dmem_ready = 1;
        ex_MemRead = 1; ex_rd = 5; id_rs2 = 5;
        check_model("lu");
        check("lu_pc", 32'(pc_write), 32'd0);
        check("lu_ifid", 32'(ifid_write), 32'd0);
        check("lu_idexfl", 32'(idex_flush), 32'd1);
        tick();
        ex_MemRead = 0; ex_rd = 0; mem_MemRead = 1; mem_RegWrite = 1; mem_rd = 5;
        check_model("lu_after");
        check("lu_after_pc", 32'(pc_write), 32'd1);
        check("lu_after_fl", 32'(idex_flush), 32'd0);
        tick();

        // Forwarding priority and x0
        zero_inputs(); dmem_ready = 1;
        mem_RegWrite = 1; mem_rd = 3; wb_RegWrite = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
        check_model("fwd_both");
        check("fwd_memprio", 32'(forwardA), 32'd2);
        mem_rd = 0;
        check_model("fwd_wb");
        check("fwd_wbonly", 32'(forwardA), 32'd1);
        wb_rd = 0;
        check_model("fwd_x0");
        check("fwd_x0", 32'(forwardA), 32'd0);
        tick();

        // Three wait cycles, released on the fourth
        zero_inputs(); mem_MemRead = 1;
        for (int i = 0; i < 3; i++) begin
            check_model("wait");
            check($sformatf("wait%0d_wr", i), 32'(writes()), 32'd0);
            tick();
        end
        dmem_ready = 1;
        check_model("wait_rel");
        check("wait_rel_wr", 32'(writes()), 32'h1f);
        tick();

        // Branch wins over load-use
        zero_inputs(); dmem_ready = 1;
        mem_PCSrc = 1; ex_MemRead = 1; ex_rd = 7; id_rs1 = 7;
        check_model("br_lu");
        check("br_flush", 32'(flushes()), 32'h7);
        check("br_pc", 32'(pc_write), 32'd1);
        check("br_ifid", 32'(ifid_write), 32'd1);
        tick();

        // Branch held during a wait is deferred to the release cycle
        zero_inputs(); mem_MemWrite = 1; mem_PCSrc = 1;
        check_model("dbr_freeze");
        check("dbr_noflush", 32'(flushes()), 32'd0);
        tick();
        check_model("dbr_wait");
        dmem_ready = 1;
        check_model("dbr_rel");
        check("dbr_flush", 32'(flushes()), 32'h7);
        tick();

        // Timeout after the TMO-th wait cycle, sticky until reset
        zero_inputs(); mem_MemRead = 1;
        check_model("tmo_run");
        tick();
        for (int i = 1; i <= TMO; i++) begin
            check_model("tmo_wait");
            check($sformatf("tmo_noerr%0d", i), 32'(mem_error), 32'd0);
            tick();
        end
        check("tmo_err", 32'(mem_error), 32'd1);
        dmem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            check_model("tmo_sticky");
            tick();
        end
        zero_inputs();
        pulse_reset("rst_err");
        check("rst_err_flag", 32'(mem_error), 32'd0);
        tick();

        // Asynchronous reset in the middle of a wait
        zero_inputs(); mem_MemRead = 1;
        tick();
        check_model("rst_wait_pre");
        zero_inputs();
        pulse_reset("rst_wait");
        check("rst_wait_wr", 32'(writes()), 32'h1f);
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            ex_MemRead   = ($urandom_range(0, 2) == 0);
            mem_RegWrite = $urandom_range(0, 1) != 0;
            wb_RegWrite  = $urandom_range(0, 1) != 0;
            mem_MemRead  = ($urandom_range(0, 3) == 0);
            mem_MemWrite = ($urandom_range(0, 5) == 0);
            mem_PCSrc    = ($urandom_range(0, 4) == 0);
            dmem_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                check_model("rnd");
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
